// File: rtl/cp0.sv
// MIPS-style coprocessor 0: SR/Cause/EPC/PRId registers, exception and interrupt
// request generation, and the eret return-address bypass.
module cp0 #(
    parameter logic [31:0] PRID = 32'h2020_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    input  logic [31:0] pc,
    input  logic [4:0]  exc_code,
    input  logic        bd,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    // EPC
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] victim_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    always_comb begin
        int_req    = (|(hw_int & im_q)) & ie_q & ~exl_q;
        exc_req    = (exc_code != 5'd0) & ~exl_q;
        req        = int_req | exc_req;
        pc_aligned = pc & 32'hFFFF_FFFC;
        // A delay-slot instruction must restart at its branch.
        victim_pc  = bd ? (pc_aligned - 32'd4) : pc_aligned;
    end

    always_comb begin
        // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latches).
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (req) begin
            // Trap entry overrides any mtc0 or eret issued in the same cycle.
            exl_d      = 1'b1;
            bd_d       = bd;
            exc_code_d = int_req ? 5'd0 : exc_code;
            epc_d      = victim_pc;
        end else begin
            if (eret) begin
                exl_d = 1'b0;
            end
            if (we) begin
                case (addr)
                    ADDR_SR: begin
                        im_d  = din[15:10];
                        exl_d = din[1];
                        ie_d  = din[0];
                    end
                    ADDR_EPC: epc_d = din;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
        cause_val = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
        case (addr)
            ADDR_SR:    dout = sr_val;
            ADDR_CAUSE: dout = cause_val;
            ADDR_EPC:   dout = epc_q;
            ADDR_PRID:  dout = PRID;
            default:    dout = 32'd0;
        endcase
        // Forward an in-flight EPC write so an immediately following eret sees it.
        epc_out = (we && addr == ADDR_EPC) ? din : epc_q;
    end

endmodule

// File: tb/tb_cp0.sv
// Table-driven bench for cp0: each record is one clock cycle of inputs plus the
// expected combinational outputs for that cycle, checked through a scoreboard queue.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h2020_0007;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
        logic [5:0]  hw;
        logic        eret;
        logic        exp_req;
        logic [31:0] exp_dout;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] pc;
    logic [4:0]  exc_code;
    logic        bd;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic        req;

    int n_pass = 0;
    int n_total = 0;
    vec_t vecs[$];
    exp_t sb[$];

    cp0 #(.PRID(PRID)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .pc       (pc),
        .exc_code (exc_code),
        .bd       (bd),
        .hw_int   (hw_int),
        .eret     (eret),
        .dout     (dout),
        .epc_out  (epc_out),
        .req      (req)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic w, input logic [4:0] a,
                                input logic [31:0] d, input logic [31:0] p,
                                input logic [4:0] e, input logic b, input logic [5:0] h,
                                input logic er, input logic xr, input logic [31:0] xd,
                                input logic [31:0] xe);
        vec_t v;
        v.rst = rst; v.we = w; v.addr = a; v.din = d; v.pc = p; v.exc = e;
        v.bd = b; v.hw = h; v.eret = er; v.exp_req = xr; v.exp_dout = xd; v.exp_epc = xe;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        reset = v.rst; we = v.we; addr = v.addr; din = v.din; pc = v.pc;
        exc_code = v.exc; bd = v.bd; hw_int = v.hw; eret = v.eret;
        e.idx = idx; e.req = v.exp_req; e.dout = v.exp_dout; e.epc = v.exp_epc;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard vec %0d: got empty queue expected one entry", idx);
        end else begin
            got = sb.pop_front();
            check("req", got.idx, {31'b0, req}, {31'b0, got.req});
            check("dout", got.idx, dout, got.dout);
            check("epc_out", got.idx, epc_out, got.epc);
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = '0; din = '0; pc = '0;
        exc_code = '0; bd = 1'b0; hw_int = '0; eret = 1'b0;
        repeat (2) @(posedge clk);

        //                 rst we addr din           pc            exc bd hw        eret req dout          epc_out
        vecs.push_back(mk(0, 0, 12, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 15, 0,            0,            0,  0, 6'b0,     0, 0, PRID,          32'h0));
        // overflow exception
        vecs.push_back(mk(0, 0, 12, 0,            32'h3010,     12, 0, 6'b0,     0, 1, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h30,        32'h3010));
        vecs.push_back(mk(0, 0, 12, 0,            0,            10, 0, 6'b0,     0, 0, 32'h2,         32'h3010));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b0,     1, 0, 32'h3010,      32'h3010));
        // delay-slot exception
        vecs.push_back(mk(0, 0, 12, 0,            32'h3024,     4,  1, 6'b0,     0, 1, 32'h0,         32'h3010));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h8000_0010, 32'h3020));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b0,     1, 0, 32'h3020,      32'h3020));
        // SR write is masked; IE=0 blocks interrupts
        vecs.push_back(mk(0, 1, 12, 32'hFFFF_FFFC, 0,           0,  0, 6'b0,     0, 0, 32'h0,         32'h3020));
        vecs.push_back(mk(0, 0, 12, 0,            0,            0,  0, 6'b000001, 0, 0, 32'h0000_FC00, 32'h3020));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h8000_0410, 32'h3020));
        // interrupt sequence
        vecs.push_back(mk(0, 1, 12, 32'h0000_0401, 0,           0,  0, 6'b0,     0, 0, 32'h0000_FC00, 32'h3020));
        vecs.push_back(mk(0, 0, 12, 0,            32'h3040,     0,  0, 6'b000001, 0, 1, 32'h401,       32'h3020));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b000001, 0, 0, 32'h400,       32'h3040));
        vecs.push_back(mk(0, 0, 12, 0,            0,            0,  0, 6'b000001, 0, 0, 32'h403,       32'h3040));
        // mtc0 EPC then eret, with the bypass
        vecs.push_back(mk(0, 1, 14, 32'h3100,     0,            0,  0, 6'b000001, 0, 0, 32'h3040,      32'h3100));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b000001, 1, 0, 32'h3100,      32'h3100));
        // held level re-raises req once EXL clears
        vecs.push_back(mk(0, 0, 12, 0,            32'h3104,     0,  0, 6'b000001, 0, 1, 32'h401,       32'h3100));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b0,     0, 0, 32'h3104,      32'h3104));
        vecs.push_back(mk(0, 0, 12, 0,            0,            0,  0, 6'b0,     1, 0, 32'h403,       32'h3104));
        // interrupt + exception + mtc0 + eret in one cycle
        vecs.push_back(mk(0, 1, 12, 32'h0,        32'h3200,     10, 0, 6'b000001, 1, 1, 32'h401,       32'h3104));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h400,       32'h3200));
        vecs.push_back(mk(0, 0, 12, 0,            0,            0,  0, 6'b0,     0, 0, 32'h403,       32'h3200));
        // writes to Cause ignored; unimplemented address reads 0
        vecs.push_back(mk(0, 1, 13, 32'hFFFF_FFFF, 0,           0,  0, 6'b0,     0, 0, 32'h0,         32'h3200));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h3200));
        vecs.push_back(mk(0, 0, 31, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h3200));
        // reset with EXL=1 and pending mtc0
        vecs.push_back(mk(1, 1, 14, 32'h5555,     0,            0,  0, 6'b0,     0, 0, 32'h3200,      32'h5555));
        vecs.push_back(mk(0, 0, 12, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 15, 0,            0,            0,  0, 6'b0,     0, 0, PRID,          32'h0));
        // unaligned pc is word-aligned into EPC
        vecs.push_back(mk(0, 0, 12, 0,            32'h3303,     5,  0, 6'b0,     0, 1, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b0,     1, 0, 32'h3300,      32'h3300));
        // reset beats a live req
        vecs.push_back(mk(1, 0, 13, 0,            32'h3400,     12, 0, 6'b0,     0, 1, 32'h14,        32'h3300));
        vecs.push_back(mk(0, 0, 14, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 13, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 12, 0,            0,            0,  0, 6'b0,     0, 0, 32'h0,         32'h0));

        foreach (vecs[i]) apply(vecs[i], i);

        // IP samples hw_int on every edge even while mtc0 targets Cause and IM masks all lines.
        apply(mk(0, 1, 13, 32'h0, 0, 0, 0, 6'b101010, 0, 0, 32'h0,         32'h0), 100);
        apply(mk(0, 0, 13, 32'h0, 0, 0, 0, 6'b010101, 0, 0, 32'h0000_A800, 32'h0), 101);
        apply(mk(0, 0, 13, 32'h0, 0, 0, 0, 6'b0,      0, 0, 32'h0000_5400, 32'h0), 102);
        // Delay-slot exception at the lowest word: EPC wraps below zero.
        apply(mk(0, 0, 13, 32'h0, 32'h0000_0002, 4, 1, 6'b0, 0, 1, 32'h0, 32'h0), 103);
        apply(mk(0, 0, 14, 32'h0, 0, 0, 0, 6'b0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC), 104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
